// File: rtl/router_arb_types.sv
// Arbitration types shared by router output arbiters.
package router_arb_types;

  typedef enum logic [1:0] {
    GRANT_NONE   = 2'd0,
    GRANT_SYS    = 2'd1,
    GRANT_NORMAL = 2'd2
  } grant_t;

  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage : router_arb_types

// File: rtl/types.sv
// Shared datapath types for the router fabric.
package types;

  typedef logic [15:0] flit_t;

endpackage : types

// File: rtl/flit_out_arbiter_if.sv
// Valid/ready flit stream; master drives valid and flit, slave drives ready.
interface flit_out_arbiter_if;
  import types::*;

  logic  valid;
  logic  ready;
  flit_t flit;

  modport master (output valid, output flit, input ready);
  modport slave  (input valid, input flit, output ready);

endinterface : flit_out_arbiter_if

// File: rtl/flit_hold_reg.sv
// One-entry flit holding register; accepts a new flit in the same cycle it drains.
module flit_hold_reg
  import types::*;
(
  input  logic               clk,
  input  logic               rst,
  flit_out_arbiter_if.slave  up,
  flit_out_arbiter_if.master dn,
  output logic               full_next
);

  logic  full_q, full_d;
  flit_t data_q, data_d;
  logic  drain;
  logic  load;

  // Ready never looks at up.valid, so there is no valid->ready combinational path.
  assign drain    = full_q & dn.ready;
  assign up.ready = ~full_q | drain;
  assign load     = up.valid & up.ready;

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = up.flit;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // NOTE: payload is not reset; it is only observed while full_q is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign dn.valid  = full_q;
  assign dn.flit   = data_q;
  assign full_next = full_d;

endmodule : flit_hold_reg

// File: rtl/flit_out_arbiter.sv
// Merges system and normal flit streams onto one output, system first.
// Define FLIT_ARB_STARVATION_GUARD_EN to force a normal win after STARVE_LIMIT lost arbitrations.
module flit_out_arbiter
  import types::*;
  import router_arb_types::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic   nocclk,
  input  logic   rst,
  input  logic   in_sys_flit_valid,
  input  flit_t  in_sys_flit,
  output logic   out_sys_ready,
  input  logic   in_normal_flit_valid,
  input  flit_t  in_normal_flit,
  output logic   out_normal_ready,
  output logic   out_flit_valid,
  output flit_t  out_flit,
  input  logic   in_flit_ready,
  output grant_t out_grant
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  flit_out_arbiter_if sys_up ();
  flit_out_arbiter_if sys_dn ();
  flit_out_arbiter_if nrm_up ();
  flit_out_arbiter_if nrm_dn ();

  grant_t grant_q, grant_d;
  logic   sys_full_nxt;
  logic   nrm_full_nxt;
  logic   xfer;
  logic   starve_hit;

  assign sys_up.valid     = in_sys_flit_valid;
  assign sys_up.flit      = in_sys_flit;
  assign out_sys_ready    = sys_up.ready;
  assign nrm_up.valid     = in_normal_flit_valid;
  assign nrm_up.flit      = in_normal_flit;
  assign out_normal_ready = nrm_up.ready;

  // A register drains only while it owns the output and downstream takes the flit.
  assign sys_dn.ready = (grant_q == GRANT_SYS)    & in_flit_ready;
  assign nrm_dn.ready = (grant_q == GRANT_NORMAL) & in_flit_ready;

  flit_hold_reg u_sys_hold (
    .clk       (nocclk),
    .rst       (rst),
    .up        (sys_up),
    .dn        (sys_dn),
    .full_next (sys_full_nxt)
  );

  flit_hold_reg u_nrm_hold (
    .clk       (nocclk),
    .rst       (rst),
    .up        (nrm_up),
    .dn        (nrm_dn),
    .full_next (nrm_full_nxt)
  );

  assign xfer = out_flit_valid & in_flit_ready;

`ifdef FLIT_ARB_STARVATION_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  // Counts system wins while a normal flit waits; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (xfer && grant_q == GRANT_NORMAL) begin
      starve_d = '0;
    end else if (xfer && grant_q == GRANT_SYS && nrm_dn.valid && starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign starve_hit = (starve_d == LIMIT);
`else
  assign starve_hit = 1'b0;
`endif

  // Ownership is decided from next-cycle occupancy so a fresh flit appears one cycle after acceptance.
  always_comb begin
    grant_d = grant_q;
    if (xfer || grant_q == GRANT_NONE) begin
      if (sys_full_nxt && nrm_full_nxt) begin
        grant_d = starve_hit ? GRANT_NORMAL : GRANT_SYS;
      end else if (sys_full_nxt) begin
        grant_d = GRANT_SYS;
      end else if (nrm_full_nxt) begin
        grant_d = GRANT_NORMAL;
      end else begin
        grant_d = GRANT_NONE;
      end
    end
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) grant_q <= GRANT_NONE;
    else     grant_q <= grant_d;
  end

  always_comb begin
    out_flit_valid = 1'b0;
    out_flit       = '0;
    unique case (grant_q)
      GRANT_SYS: begin
        out_flit_valid = sys_dn.valid;
        out_flit       = sys_dn.flit;
      end
      GRANT_NORMAL: begin
        out_flit_valid = nrm_dn.valid;
        out_flit       = nrm_dn.flit;
      end
      default: ;
    endcase
  end

  assign out_grant = grant_q;

endmodule : flit_out_arbiter

// File: tb/tb_flit_out_arbiter.sv
// Directed bench for flit_out_arbiter; expectations follow FLIT_ARB_STARVATION_GUARD_EN.
module tb_flit_out_arbiter;
  import types::*;
  import router_arb_types::*;

  logic   nocclk = 1'b0;
  logic   rst;
  grant_t grant;
  int     passed = 0;
  int     total  = 0;

  flit_out_arbiter_if sys_if ();
  flit_out_arbiter_if nrm_if ();
  flit_out_arbiter_if out_if ();

  always #5 nocclk = ~nocclk;

  flit_out_arbiter #(.STARVE_LIMIT(4)) dut (
    .nocclk               (nocclk),
    .rst                  (rst),
    .in_sys_flit_valid    (sys_if.valid),
    .in_sys_flit          (sys_if.flit),
    .out_sys_ready        (sys_if.ready),
    .in_normal_flit_valid (nrm_if.valid),
    .in_normal_flit       (nrm_if.flit),
    .out_normal_ready     (nrm_if.ready),
    .out_flit_valid       (out_if.valid),
    .out_flit             (out_if.flit),
    .in_flit_ready        (out_if.ready),
    .out_grant            (grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"},  32'(out_if.valid), 32'd0);
    check({tag, "_grant"},  32'(grant),        32'(GRANT_NONE));
    check({tag, "_sysrdy"}, 32'(sys_if.ready), 32'd1);
    check({tag, "_nrmrdy"}, 32'(nrm_if.ready), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    sys_if.valid = 1'b0;
    sys_if.flit  = '0;
    nrm_if.valid = 1'b0;
    nrm_if.flit  = '0;
    out_if.ready = 1'b0;

    // Reset state
    #2;
    check_idle("rst");
    check("rst_flit", 32'(out_if.flit), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // System stream only, downstream always ready: three flits back to back
    out_if.ready = 1'b1;
    sys_if.valid = 1'b1;
    sys_if.flit  = 16'h00A1;
    tick();
    check("sys1_flit",  32'(out_if.flit),  32'h00A1);
    check("sys1_grant", 32'(grant),        32'(GRANT_SYS));
    check("sys1_valid", 32'(out_if.valid), 32'd1);
    check("sys1_rdy",   32'(sys_if.ready), 32'd1);
    sys_if.flit = 16'h00A2;
    tick();
    check("sys2_flit",  32'(out_if.flit),  32'h00A2);
    check("sys2_valid", 32'(out_if.valid), 32'd1);
    sys_if.flit = 16'h00A3;
    tick();
    check("sys3_flit",  32'(out_if.flit),  32'h00A3);
    check("sys3_grant", 32'(grant),        32'(GRANT_SYS));
    sys_if.valid = 1'b0;
    tick();
    check_idle("sys_end");

    // Single normal flit with system idle
    nrm_if.valid = 1'b1;
    nrm_if.flit  = 16'h005A;
    tick();
    check("nrm_flit",  32'(out_if.flit),  32'h005A);
    check("nrm_grant", 32'(grant),        32'(GRANT_NORMAL));
    check("nrm_valid", 32'(out_if.valid), 32'd1);
    nrm_if.valid = 1'b0;
    tick();
    check_idle("nrm_end");

    // Stall: both registers full, downstream blocked, new data offered must not overwrite
    out_if.ready = 1'b0;
    sys_if.valid = 1'b1;
    sys_if.flit  = 16'h00B1;
    nrm_if.valid = 1'b1;
    nrm_if.flit  = 16'h00C1;
    tick();
    sys_if.flit = 16'h00B2;
    nrm_if.flit = 16'h00C2;
    for (int c = 0; c < 5; c++) begin
      check("stall_flit",   32'(out_if.flit),  32'h00B1);
      check("stall_grant",  32'(grant),        32'(GRANT_SYS));
      check("stall_sysrdy", 32'(sys_if.ready), 32'd0);
      check("stall_nrmrdy", 32'(nrm_if.ready), 32'd0);
      tick();
    end

    // Asynchronous reset pulse mid-stall discards both held flits
    sys_if.valid = 1'b0;
    nrm_if.valid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle("rst_stall");
    #1;
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    // Both sources continuously valid, downstream always ready
    out_if.ready = 1'b1;
    sys_if.valid = 1'b1;
    sys_if.flit  = 16'h0111;
    nrm_if.valid = 1'b1;
    nrm_if.flit  = 16'h0222;
    for (int c = 1; c <= 10; c++) begin
      tick();
`ifdef FLIT_ARB_STARVATION_GUARD_EN
      if (c % 5 == 0) begin
        check("starve_grant", 32'(grant),       32'(GRANT_NORMAL));
        check("starve_flit",  32'(out_if.flit), 32'h0222);
      end else begin
        check("starve_grant", 32'(grant),       32'(GRANT_SYS));
        check("starve_flit",  32'(out_if.flit), 32'h0111);
      end
`else
      check("strict_grant",  32'(grant),        32'(GRANT_SYS));
      check("strict_flit",   32'(out_if.flit),  32'h0111);
      check("strict_nrmrdy", 32'(nrm_if.ready), 32'd0);
`endif
    end

    sys_if.valid = 1'b0;
    nrm_if.valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_flit_out_arbiter

// File: doc/flit_out_arbiter.md
FLIT_OUT_ARBITER -- requirements
Module: flit_out_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost arbitrations before the normal source is forced to win; legal range 1..15.
REQ-002 SHALL have port nocclk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_sys_flit_valid, input, 1: system flit offered.
REQ-005 SHALL have port in_sys_flit, input, types::flit_t: system flit data.
REQ-006 SHALL have port out_sys_ready, output, 1: system flit accepted when high together with valid.
REQ-007 SHALL have port in_normal_flit_valid, input, 1: normal flit offered.
REQ-008 SHALL have port in_normal_flit, input, types::flit_t: normal flit data.
REQ-009 SHALL have port out_normal_ready, output, 1: normal flit accepted when high together with valid.
REQ-010 SHALL have port out_flit_valid, output, 1: merged output valid.
REQ-011 SHALL have port out_flit, output, types::flit_t: merged output flit.
REQ-012 SHALL have port in_flit_ready, input, 1: downstream accepts out_flit this cycle.
REQ-013 SHALL have port out_grant, output, router_arb_types::grant_t: current owner (GRANT_NONE, GRANT_SYS, GRANT_NORMAL).

Function
REQ-014 SHALL hold one flit per source in a holding register; input to out_flit latency is exactly 1 cycle when uncontended.
REQ-015 SHALL drive per-source ready = holding register empty, or holding register drains this cycle (granted and in_flit_ready).
REQ-016 SHALL never set ready combinationally from in_*_valid.
REQ-017 SHALL run the grant FSM: GRANT_NONE when both registers are empty; otherwise choose an owner per REQ-018/019.
REQ-018 SHALL give GRANT_SYS priority when both registers are full, except as REQ-019 states.
REQ-019 SHALL grant GRANT_NORMAL when the starvation counter equals STARVE_LIMIT and the normal register is full.
REQ-020 SHALL keep out_grant and out_flit stable while out_flit_valid=1 and in_flit_ready=0; no re-arbitration during a stall.
REQ-021 SHALL re-arbitrate only in the cycle after a transfer (valid and in_flit_ready), or from GRANT_NONE.
REQ-022 SHALL increment the 4-bit starvation counter on each sys transfer while the normal register is full.
REQ-023 SHALL clear the starvation counter on a normal transfer; the counter saturates at STARVE_LIMIT.
REQ-024 SHALL, with one register full, grant that source immediately regardless of the counter.
REQ-025 SHALL load a source register in the same cycle it drains when new input is offered (back-to-back, full throughput).

Reset
REQ-026 SHALL on rst: empty both registers, out_grant=GRANT_NONE, out_flit_valid=0, out_flit='0, starvation counter=0, out_sys_ready=1, out_normal_ready=1.
REQ-027 SHALL discard held flits if rst asserts mid-stall; no flit is presented after reset until newly accepted.

Configuration
REQ-028 SHALL, with FLIT_ARB_STARVATION_GUARD_EN defined, implement REQ-019, REQ-022 and REQ-023.
REQ-029 SHALL, without FLIT_ARB_STARVATION_GUARD_EN, use strict system priority, omit the counter, and ignore STARVE_LIMIT.

Structure
REQ-030 SHALL place grant_t and the default STARVE_LIMIT constant in shared package router_arb_types; flit_t stays in types.
REQ-031 SHALL implement the holding register as sub-module flit_hold_reg, instantiated twice.

Verification
REQ-032 Sys-only: sys valid 3 cycles, in_flit_ready=1 -> out_flit = each flit 1 cycle later, out_grant=GRANT_SYS, no bubble.
REQ-033 Stall: both full, in_flit_ready=0 for 5 cycles -> out_flit and GRANT_SYS constant, both readies=0.
REQ-034 Starvation with guard on, STARVE_LIMIT=4, both continuously valid -> pattern 4 sys, 1 normal, repeating; counter resets to 0 after the normal transfer.
REQ-035 Guard off, same stimulus -> normal never granted; out_normal_ready stays 0 after the first load.
REQ-036 Reset mid-stall: rst pulse with both full -> next cycle out_flit_valid=0, GRANT_NONE, both readies=1.
REQ-037 Single normal flit 0x5A while sys idle -> out_flit=0x5A next cycle, GRANT_NORMAL, then GRANT_NONE.
